// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable width, parity and stop bits, 16x oversampling,
// 3-sample majority vote, parity/framing/break detection and a valid/ready output.
module uart_rx_cfg #(
  parameter int UART_INPUT_CLK = 100_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int OVERSAMPLE     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);
  localparam int DIV = UART_INPUT_CLK / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] D_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A     = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_B     = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_C     = SW'(OVERSAMPLE/2 + 1);
  localparam logic [3:0]    DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;
  state_t state, state_n;

  logic                 rx_m, rxs, rxs_d;
  logic [DW-1:0]        div_cnt;
  logic [SW-1:0]        s_cnt;
  logic                 tick, decide, samp_a, samp_b, bitv;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, par_exp, perr_acc, ferr_acc;
  logic                 start_edge, done, brk_hit;

  // 2-FF synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m  <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_m  <= rx;
      rxs   <= rx_m;
      rxs_d <= rxs;
    end
  end

  // tick and sample counters restart from zero on every start edge
  assign tick = (state != IDLE) && (div_cnt == D_LAST);

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      div_cnt <= '0;
      s_cnt   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (tick) begin
      if (s_cnt == S_A) samp_a <= rxs;
      if (s_cnt == S_B) samp_b <= rxs;
    end
  end

  assign decide  = tick && (s_cnt == S_C);
  assign bitv    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign par_exp = (PARITY == 2) ? ~^shreg : ^shreg;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (state != IDLE && !rx_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:     if (start_edge) state_n = START;
        START:    if (decide) state_n = bitv ? IDLE : DATA;
        DATA:     if (decide && bit_cnt == DB_LAST) state_n = (PARITY != 0) ? PAR : STOP;
        PAR:      if (decide) state_n = STOP;
        STOP: begin
          if (brk_hit)   state_n = BRK_WAIT;
          else if (done) state_n = IDLE;
        end
        BRK_WAIT: if (rxs) state_n = IDLE;
        default:  state_n = IDLE;
      endcase
    end
  end

  // break is judged at the first stop bit; frames complete at the last one
  always_comb begin
    start_edge = rx_en && rxs_d && !rxs;
    brk_hit    = 1'b0;
    done       = 1'b0;
    if (rx_en && state == STOP && decide) begin
      brk_hit = (bit_cnt == '0) && !bitv && (shreg == '0) && ((PARITY == 0) || !par_bit);
      done    = !brk_hit && (bit_cnt == SB_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (state != state_n)
        bit_cnt <= '0;
      else if (decide && (state == DATA || state == STOP))
        bit_cnt <= bit_cnt + 1'b1;
      if (state == IDLE) begin
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (state == DATA && decide) shreg <= {bitv, shreg[DATA_BITS-1:1]};
      if (state == PAR && decide) begin
        par_bit  <= bitv;
        perr_acc <= bitv ^ par_exp;
      end
      if (state == STOP && decide && !bitv) ferr_acc <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      break_det <= brk_hit;
      busy      <= (state_n != IDLE);
      if (valid && ready) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      if (done) begin
        if (!valid || ready) begin
          data       <= shreg;
          parity_err <= perr_acc;
          frame_err  <= ferr_acc | !bitv;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 unit and a 7E2 unit driven with bit-accurate
// serial frames; expectations come from a frame-level model of the line rules.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  localparam int CLK_HZ = 800_000;
  localparam int BAUD   = 10_000;
  localparam int OS     = 16;
  localparam int BIT    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic rst, rx_en, rx0, rx1, ready0, ready1;
  logic [7:0] d0;
  logic [6:0] d1;
  logic v0, pe0, fe0, ov0, bk0, by0;
  logic v1, pe1, fe1, ov1, bk1, by1;
  int checks = 0, errors = 0;
  logic [10:0] q0[$], q1[$];
  int brk0 = 0, brk1 = 0, vcyc0 = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.UART_INPUT_CLK(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .OVERSAMPLE(OS)) u0 (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rx(rx0), .data(d0), .valid(v0), .ready(ready0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .break_det(bk0), .busy(by0));

  uart_rx_cfg #(.UART_INPUT_CLK(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                .STOP_BITS(2), .OVERSAMPLE(OS)) u1 (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rx(rx1), .data(d1), .valid(v1), .ready(ready1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .break_det(bk1), .busy(by1));

  // record accepted frames and break pulses
  always @(negedge clk) begin
    if (v0 && ready0) q0.push_back({pe0, fe0, 1'b0, d0});
    if (v1 && ready1) q1.push_back({pe1, fe1, 2'b0, d1});
    if (bk0) brk0++;
    if (bk1) brk1++;
    if (v0) vcyc0++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int u, input logic b);
    if (u == 0) rx0 = b;
    else        rx1 = b;
  endtask

  function automatic logic evenp(input logic [8:0] d, input int nb);
    logic p = 1'b0;
    for (int i = 0; i < nb; i++) p ^= d[i];
    return p;
  endfunction

  // frame-level model: {is_break, parity_err, frame_err, data[8:0]}
  function automatic logic [11:0] model(input int u, input logic [8:0] d, input logic pflip,
                                        input logic slow);
    int nb = (u == 0) ? 8 : 7;
    logic [8:0] m = 9'((1 << nb) - 1);
    logic pbit = evenp(d, nb) ^ pflip;
    logic brk = ((d & m) == 9'd0) && slow && ((u == 0) || !pbit);
    logic pe = (u == 1) && pflip;
    return {brk, pe, slow, d & m};
  endfunction

  // gbit: index into the line bit sequence (0 = start) that gets a 1-clock glitch
  task automatic send_frame(input int u, input logic [8:0] d, input logic pflip,
                            input logic slow, input int gbit);
    int nb = (u == 0) ? 8 : 7;
    int ns = (u == 0) ? 1 : 2;
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(d[i]);
    if (u == 1) bits.push_back(evenp(d, nb) ^ pflip);
    for (int i = 0; i < ns; i++) bits.push_back(!slow);
    foreach (bits[k]) begin
      set_rx(u, bits[k]);
      if (k == gbit) begin
        step(BIT/2);
        set_rx(u, !bits[k]);
        step(1);
        set_rx(u, bits[k]);
        step(BIT - BIT/2 - 1);
      end else begin
        step(BIT);
      end
    end
    set_rx(u, 1'b1);
    step(BIT + BIT/2);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_en = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    step(3);
    @(negedge clk);
    checks++;
    if ({v0, pe0, fe0, ov0, bk0, by0, d0} !== 14'd0) begin
      errors++; $display("FAIL reset_u0 got %h want 0", {v0, pe0, fe0, ov0, bk0, by0, d0});
    end
    checks++;
    if ({v1, pe1, fe1, ov1, bk1, by1, d1} !== 13'd0) begin
      errors++; $display("FAIL reset_u1 got %h want 0", {v1, pe1, fe1, ov1, bk1, by1, d1});
    end
    step(1);
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_basic();
    logic [10:0] e;
    q0.delete(); vcyc0 = 0;
    send_frame(0, 9'h0A5, 1'b0, 1'b0, -1);
    @(negedge clk);
    checks++;
    if (q0.size() !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", q0.size()); end
    e = (q0.size() > 0) ? q0[0] : 11'h7FF;
    checks++;
    if (e !== 11'h0A5) begin errors++; $display("FAIL basic_frame got %h want 0a5", e); end
    checks++;
    if (vcyc0 !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d want 1", vcyc0); end
    checks++;
    if (by0 !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", by0); end
  endtask

  task automatic test_parity();
    logic [10:0] e;
    q1.delete();
    send_frame(1, 9'h041, 1'b1, 1'b0, -1);
    @(negedge clk);
    e = (q1.size() == 1) ? q1[0] : 11'h7FF;
    checks++;
    if (e !== {1'b1, 1'b0, 9'h041}) begin
      errors++; $display("FAIL parity_frame got %h want %h", e, {1'b1, 1'b0, 9'h041});
    end
    checks++;
    if (by1 !== 1'b0) begin errors++; $display("FAIL parity_busy got %b want 0", by1); end
  endtask

  task automatic test_frame_err();
    logic [10:0] e;
    q0.delete();
    send_frame(0, 9'h03C, 1'b0, 1'b1, -1);
    @(negedge clk);
    e = (q0.size() == 1) ? q0[0] : 11'h7FF;
    checks++;
    if (e !== {1'b0, 1'b1, 9'h03C}) begin
      errors++; $display("FAIL frame_err got %h want %h", e, {1'b0, 1'b1, 9'h03C});
    end
  endtask

  task automatic test_random();
    int u, b0, b1, qs, bd;
    logic [8:0] d;
    logic pflip, slow;
    logic [11:0] m;
    logic [10:0] e;
    for (int i = 0; i < 8; i++) begin
      u = $urandom_range(0, 1);
      d = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 4) == 0) d = 9'd0;
      pflip = 1'($urandom_range(0, 1));
      slow  = ($urandom_range(0, 2) == 0);
      m = model(u, d, pflip, slow);
      q0.delete(); q1.delete(); b0 = brk0; b1 = brk1;
      send_frame(u, d, pflip, slow, -1);
      @(negedge clk);
      qs = (u == 0) ? q0.size() : q1.size();
      bd = (u == 0) ? brk0 - b0 : brk1 - b1;
      checks++;
      if (qs !== (m[11] ? 0 : 1) || bd !== (m[11] ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d_count u%0d frames %0d breaks %0d want brk=%b", i, u, qs, bd, m[11]);
      end
      if (!m[11]) begin
        e = (qs == 1) ? ((u == 0) ? q0[0] : q1[0]) : 11'h7FF;
        checks++;
        if (e !== m[10:0]) begin
          errors++; $display("FAIL rand%0d_frame u%0d got %h want %h", i, u, e, m[10:0]);
        end
      end
    end
  endtask

  task automatic test_break();
    int b;
    q0.delete(); b = brk0;
    rx0 = 1'b0;
    step(12*BIT);
    @(negedge clk);
    checks++;
    if (brk0 - b !== 1) begin errors++; $display("FAIL break_pulses got %0d want 1", brk0 - b); end
    checks++;
    if (q0.size() !== 0 || v0 !== 1'b0) begin
      errors++; $display("FAIL break_noframe got %0d/%b want 0/0", q0.size(), v0);
    end
    checks++;
    if (by0 !== 1'b1) begin errors++; $display("FAIL break_busy_held got %b want 1", by0); end
    rx0 = 1'b1;
    step(10);
    @(negedge clk);
    checks++;
    if (by0 !== 1'b0) begin errors++; $display("FAIL break_idle got %b want 0", by0); end
    step(BIT);
  endtask

  task automatic test_overrun();
    ready0 = 1'b0;
    send_frame(0, 9'h011, 1'b0, 1'b0, -1);
    send_frame(0, 9'h022, 1'b0, 1'b0, -1);
    @(negedge clk);
    checks++;
    if ({v0, ov0, d0} !== {1'b1, 1'b1, 8'h11}) begin
      errors++; $display("FAIL overrun_hold got %h want %h", {v0, ov0, d0}, {1'b1, 1'b1, 8'h11});
    end
    @(posedge clk); #1;
    ready0 = 1'b1;
    step(1);
    ready0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({v0, ov0} !== 2'b00) begin
      errors++; $display("FAIL overrun_clear got %b want 00", {v0, ov0});
    end
    ready0 = 1'b1;
    step(2);
    q0.delete();
  endtask

  task automatic test_glitch();
    logic [10:0] e;
    q0.delete();
    rx0 = 1'b0; step(3); rx0 = 1'b1;
    step(2*BIT);
    @(negedge clk);
    checks++;
    if (q0.size() !== 0 || by0 !== 1'b0) begin
      errors++; $display("FAIL false_start got %0d/%b want 0/0", q0.size(), by0);
    end
    send_frame(0, 9'h05A, 1'b0, 1'b0, 4);
    send_frame(0, 9'h0C3, 1'b0, 1'b0, 1);
    @(negedge clk);
    checks++;
    if (q0.size() !== 2) begin errors++; $display("FAIL glitch_count got %0d want 2", q0.size()); end
    e = (q0.size() > 0) ? q0[0] : 11'h7FF;
    checks++;
    if (e !== 11'h05A) begin errors++; $display("FAIL glitch_a got %h want 05a", e); end
    e = (q0.size() > 1) ? q0[1] : 11'h7FF;
    checks++;
    if (e !== 11'h0C3) begin errors++; $display("FAIL glitch_b got %h want 0c3", e); end
  endtask

  task automatic test_disable();
    ready0 = 1'b0;
    send_frame(0, 9'h077, 1'b0, 1'b0, -1);
    fork
      send_frame(0, 9'h0E1, 1'b0, 1'b0, -1);
      begin
        step(3*BIT);
        rx_en = 1'b0;
        step(2);
        @(negedge clk);
        checks++;
        if (by0 !== 1'b0) begin errors++; $display("FAIL disable_abort got %b want 0", by0); end
      end
    join
    @(negedge clk);
    checks++;
    if ({v0, ov0, pe0, fe0, d0} !== {4'b1000, 8'h77}) begin
      errors++; $display("FAIL disable_keep got %h want %h", {v0, ov0, pe0, fe0, d0}, {4'b1000, 8'h77});
    end
    @(posedge clk); #1;
    rx_en = 1'b1; ready0 = 1'b1;
    step(2);
    q0.delete();
  endtask

  task automatic test_rst_mid();
    ready0 = 1'b0;
    send_frame(0, 9'h05A, 1'b0, 1'b0, -1);
    fork
      send_frame(0, 9'h0C3, 1'b0, 1'b0, -1);
      begin
        step(4*BIT);
        @(negedge clk);
        checks++;
        if ({v0, by0} !== 2'b11) begin errors++; $display("FAIL rst_pre got %b want 11", {v0, by0}); end
        @(posedge clk); #1;
        rst = 1'b1;
        step(1);
        @(negedge clk);
        checks++;
        if ({v0, pe0, fe0, ov0, bk0, by0, d0} !== 14'd0) begin
          errors++; $display("FAIL rst_mid got %h want 0", {v0, pe0, fe0, ov0, bk0, by0, d0});
        end
      end
    join
    @(posedge clk); #1;
    rst = 1'b0; ready0 = 1'b1;
    step(4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_random();
    test_break();
    test_overrun();
    test_glitch();
    test_disable();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
